mat_result_serializer: RTL and testbench

Drains the flattened `N*N*W_OUT` result of the matrix multiplier one element per handshake. It captures a whole result matrix when `valid_in` is accepted, then emits elements on a valid/ready stream tagged with row/column indices and a last flag. It sits between the multiplier's `result`/`valid_out` pair and the writeback path. Full-rate streaming gives one matrix per `N*N` cycles with no bubbles between matrices.

---
 rtl/mat_result_serializer.sv | 80 ++++++++
 tb/tb_mat_result_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_result_serializer.sv
// mat_result_serializer: captures a flattened N*N result matrix and streams it one element per valid/ready handshake.
//   clk, rst (sync, active-high), cen (clock enable)
//   valid_in/result/in_ready : matrix input; in_ready also opens on the final output handshake
//   out_valid/out_ready      : element stream handshake
//   out_data/out_row/out_col/out_last : registered element value, position and end-of-matrix flag
//   overflow                 : sticky, a matrix was offered while in_ready was low
//   Define MAT_SER_COL_MAJOR_EN for column-major traversal (default row-major).
module mat_result_serializer #(
  parameter int W_OUT = 32,
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         valid_in,
  input  logic signed [N*N*W_OUT-1:0]  result,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [W_OUT-1:0]      out_data,
  output logic [$clog2(N)-1:0]         out_row,
  output logic [$clog2(N)-1:0]         out_col,
  output logic                         out_last,
  output logic                         overflow
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] MAX = IW'(N-1);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [N*N*W_OUT-1:0] mat_q, mat_d;
  logic signed [W_OUT-1:0] data_q, data_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d, nrow, ncol;
  logic last_q, last_d, ovf_q, ovf_d, acc, adv, fin;
  assign out_valid = (state_q == DRAIN);
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign overflow  = ovf_q;
  always_comb begin
    in_ready = (state_q == IDLE) | (out_valid & out_ready & last_q);
    acc = cen & valid_in & in_ready;
    fin = cen & out_valid & out_ready & last_q;
    adv = cen & out_valid & out_ready & !last_q;
`ifdef MAT_SER_COL_MAJOR_EN
    nrow = (row_q == MAX) ? '0 : row_q + IW'(1);
    ncol = (row_q == MAX) ? col_q + IW'(1) : col_q;
`else
    ncol = (col_q == MAX) ? '0 : col_q + IW'(1);
    nrow = (col_q == MAX) ? row_q + IW'(1) : row_q;
`endif
    state_d = acc ? DRAIN : fin ? IDLE : state_q;
    mat_d   = acc ? result : mat_q;
    row_d   = acc ? '0 : adv ? nrow : row_q;
    col_d   = acc ? '0 : adv ? ncol : col_q;
    // On accept, element (0,0) comes straight from the input bus since the buffer is loaded on the same edge.
    data_d  = acc ? result[W_OUT-1:0] : adv ? mat_q[(int'(nrow)*N + int'(ncol))*W_OUT +: W_OUT] : data_q;
    last_d  = acc ? 1'b0 : adv ? ((nrow == MAX) && (ncol == MAX)) : last_q;
    ovf_d   = ovf_q | (cen & valid_in & !in_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mat_result_serializer.sv
// tb_mat_result_serializer: directed and randomized checks of mat_result_serializer against a queue-based model.
module tb_mat_result_serializer;
  localparam int N = 2;
  localparam int W = 32;
  logic clk, rst, cen, valid_in, out_ready;
  logic signed [N*N*W-1:0] result;
  logic in_ready, out_valid, out_last, overflow;
  logic signed [W-1:0] out_data;
  logic [$clog2(N)-1:0] out_row, out_col;
  int total = 0;
  int bad = 0;
  mat_result_serializer #(.W_OUT(W), .N(N)) dut (
    .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in), .result(result),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct { logic signed [W-1:0] d; int r; int c; bit l; } el_t;
  el_t mq[$];
  bit m_ovf = 1'b0;
  function automatic bit m_in_ready();
    return (mq.size() == 0) || (out_ready && mq[0].l);
  endfunction
  // Reference: a queue of the elements still owed downstream, refilled whole on every accepted matrix.
  initial forever begin
    bit rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (cen) begin
      rdy = m_in_ready();
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (valid_in && !rdy) m_ovf = 1'b1;
      if (valid_in && rdy)
        for (int a = 0; a < N; a++)
          for (int b = 0; b < N; b++) begin
            el_t e;
`ifdef MAT_SER_COL_MAJOR_EN
            e.r = b; e.c = a;
`else
            e.r = a; e.c = b;
`endif
            e.d = result[(e.r*N + e.c)*W +: W];
            e.l = (e.r == N-1) && (e.c == N-1);
            mq.push_back(e);
          end
    end
  end
  // Linear element index (r*N+c) of the i-th element emitted for N=2.
  function automatic int ord(input int i);
`ifdef MAT_SER_COL_MAJOR_EN
    return (i == 1) ? 2 : (i == 2) ? 1 : i;
`else
    return i;
`endif
  endfunction
  task automatic drive_mat(input int a, input int b, input int c, input int d);
    result = {d, c, b, a};
    valid_in = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; valid_in = 1'b0; out_ready = 1'b0; result = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 0) begin bad++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    total++; if (out_row !== 0 || out_col !== 0) begin bad++; $display("FAIL reset_idx got=(%0d,%0d) exp=(0,0)", out_row, out_col); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_basic();
    int m[4] = '{1, 2, 3, -4};
    out_ready = 1'b1;
    drive_mat(1, 2, 3, -4);
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_data !== m[ord(i)]) begin bad++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, out_data, m[ord(i)]); end
      total++; if (out_row !== ord(i)/2 || out_col !== ord(i)%2) begin bad++; $display("FAIL basic_idx[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, out_row, out_col, ord(i)/2, ord(i)%2); end
      total++; if (out_last !== (i == 3)) begin bad++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, out_last, i == 3); end
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b exp=0", out_valid); end
  endtask
  task automatic test_backpressure();
    int m[4] = '{1, 2, 3, -4};
    out_ready = 1'b1;
    drive_mat(1, 2, 3, -4);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++; if (out_data !== m[ord(1)] || out_row !== ord(1)/2 || out_col !== ord(1)%2 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%0d(%0d,%0d) v=%b exp=%0d(%0d,%0d) v=1", out_data, out_row, out_col, out_valid, m[ord(1)], ord(1)/2, ord(1)%2); end
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_data !== m[ord(i)] || out_last !== (i == 3)) begin bad++; $display("FAIL bp_resume[%0d] got=%0d last=%b exp=%0d last=%b", i, out_data, out_last, m[ord(i)], i == 3); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
  endtask
  task automatic test_back_to_back();
    int m[4] = '{1, 2, 3, -4};
    int n[4] = '{5, 6, 7, 8};
    out_ready = 1'b1;
    drive_mat(1, 2, 3, -4);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_data !== m[3] || out_last !== 1'b1) begin bad++; $display("FAIL b2b_last got=%0d last=%b exp=%0d last=1", out_data, out_last, m[3]); end
    drive_mat(5, 6, 7, 8);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== n[ord(i)] || out_row !== ord(i)/2 || out_col !== ord(i)%2) begin bad++; $display("FAIL b2b_elem[%0d] got=%0d(%0d,%0d) v=%b exp=%0d(%0d,%0d) v=1", i, out_data, out_row, out_col, out_valid, n[ord(i)], ord(i)/2, ord(i)%2); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
  endtask
  task automatic test_overflow();
    int m[4] = '{1, 2, 3, -4};
    out_ready = 1'b1;
    drive_mat(1, 2, 3, -4);
    @(negedge clk);
    drive_mat(9, 9, 9, 9);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%b exp=0", in_ready); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag[%0d] got=%b exp=1", i, overflow); end
      total++; if (out_data !== m[ord(i)] || out_valid !== 1'b1) begin bad++; $display("FAIL ovf_stream[%0d] got=%0d v=%b exp=%0d v=1", i, out_data, out_valid, m[ord(i)]); end
    end
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got v=%b ovf=%b exp v=0 ovf=1", out_valid, overflow); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask
  task automatic test_cen();
    int m[4] = '{11, -12, 13, 14};
    out_ready = 1'b1;
    drive_mat(11, -12, 13, 14);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    cen = 1'b0;
    drive_mat(7, 7, 7, 7);
    repeat (4) begin
      @(negedge clk);
      total++; if (out_data !== m[ord(1)] || out_valid !== 1'b1 || out_row !== ord(1)/2 || out_col !== ord(1)%2) begin bad++; $display("FAIL cen_hold got=%0d(%0d,%0d) v=%b exp=%0d(%0d,%0d) v=1", out_data, out_row, out_col, out_valid, m[ord(1)], ord(1)/2, ord(1)%2); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL cen_overflow got=%b exp=0", overflow); end
    end
    cen = 1'b1;
    valid_in = 1'b0;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_data !== m[ord(i)]) begin bad++; $display("FAIL cen_resume[%0d] got=%0d exp=%0d", i, out_data, m[ord(i)]); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cen_end_valid got=%b exp=0", out_valid); end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_mat(1, 2, 3, -4);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== 0) begin bad++; $display("FAIL rstmid_out got v=%b d=%0d exp v=0 d=0", out_valid, out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    drive_mat(21, 22, 23, 24);
    @(negedge clk);
    valid_in = 1'b0;
    total++; if (out_data !== 21 || out_row !== 0 || out_col !== 0 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_restart got=%0d(%0d,%0d) v=%b exp=21(0,0) v=1", out_data, out_row, out_col, out_valid); end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_random();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", k, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        total++; if (out_data !== mq[0].d || out_row !== mq[0].r || out_col !== mq[0].c || out_last !== mq[0].l) begin bad++; $display("FAIL rnd_elem[%0d] got=%0d(%0d,%0d) l=%b exp=%0d(%0d,%0d) l=%b", k, out_data, out_row, out_col, out_last, mq[0].d, mq[0].r, mq[0].c, mq[0].l); end
      end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow[%0d] got=%b exp=%b", k, overflow, m_ovf); end
      rst = ($urandom_range(0, 99) == 0);
      cen = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      valid_in = ($urandom_range(0, 3) == 0);
      result = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++; if (in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", k, in_ready, m_in_ready()); end
      @(negedge clk);
    end
    rst = 1'b0; cen = 1'b1; valid_in = 1'b0;
  endtask
  initial begin
    rst = 1'b1; cen = 1'b1; valid_in = 1'b0; out_ready = 1'b0; result = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_cen();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
